nbcac_encoder_arbiter: RTL and testbench
========================================

# nbcac_encoder_arbiter

Shares a single `nbcac_13di_encoder_core` (13-bit data → 18-bit NBCAC codeword) between `NUM_CH` requesting channels. Arbitration is round-robin with optional multi-word packet locking. The block drives one registered, backpressurable codeword stream toward the crosstalk-avoidance bus. When no new word is sent, it holds the last codeword on the bus so that idle cycles cause zero wire transitions.

## Interface
Parameters:
- `NUM_CH`, default 4: number of requesters; legal range 2..16.
- `CH_W`, default `$clog2(NUM_CH)`: channel-id width. Derived; do not override.

Ports:
- `clock`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_CH: per-channel word valid.
- `req_data`  in  NUM_CH*13: channel i occupies bits [13*i+12 : 13*i].
- `req_last`  in  NUM_CH: marks the final word of a packet. Sampled only with an accepted word.
- `req_ready`  out  NUM_CH: one-hot or zero. Channel i's word is accepted on a cycle where `req_valid[i] && req_ready[i]`.
- `out_valid`  out  1: `out_code` carries a new codeword.
- `out_ready`  in  1: downstream accepts the word.
- `out_code`  out  18: NBCAC codeword, registered.
- `out_ch`  out  CH_W: source channel of `out_code`.
- `out_last`  out  1: copy of the accepted `req_last`.

## Operation
- The output stage is a single register. `load = !out_valid || out_ready`.
- Arbiter state machine:
  - **IDLE**: the grant goes to the first channel with `req_valid` set, searching from `rr_ptr` upward with wrap (`NUM_CH-1` → 0).
  - **LOCKED**: the grant stays fixed on `lock_ch`. Other channels are never granted, even if `lock_ch` deasserts `req_valid`.
- `req_ready[g] = load && grant_valid`, where g is the granted channel. `req_ready` depends combinationally on `out_ready` and `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- On acceptance from channel g:
  - `out_code <= core(req_data[g])`, `out_ch <= g`, `out_last <= req_last[g]`, `out_valid <= 1`.
  - If `req_last[g]=1`: next state IDLE, `rr_ptr <= (g+1) mod NUM_CH`.
  - If `req_last[g]=0`: next state LOCKED, `lock_ch <= g`. `rr_ptr` is unchanged.
- If `out_ready && out_valid` and there is no acceptance: `out_valid <= 0`. `out_code`, `out_ch` and `out_last` HOLD their values (bus idle hold). They are never cleared outside reset.
- Stall (`out_valid && !out_ready`): all outputs and state are frozen and every `req_ready` bit is 0.
- Reset: `out_valid=0`, `out_code=18'h0`, `out_ch=0`, `out_last=0`, state IDLE, `rr_ptr=0`, `lock_ch=0`.
- Reset asserted mid-packet: the lock is dropped and the next grant restarts from channel 0. The partial packet is the requester's responsibility.

## Timing
- Latency: a word accepted in cycle n appears on `out_code` with `out_valid=1` in cycle n+1.
- Throughput: one word per cycle while `out_ready=1`.
- A simultaneous drain and accept in the same cycle is legal and keeps `out_valid=1` without a bubble.
- Grant fairness: in IDLE, a channel with continuous `req_valid` waits at most `NUM_CH-1` packets.
- The encoder core is combinational between the `req_data` mux and the `out_code` register. There are no other pipeline stages.

## Structure
- Shared package `nbcac_pkg` holds:
  - `NBCAC_DW=13`, `NBCAC_CW=18`;
  - the state enum `arb_state_t {ARB_IDLE, ARB_LOCKED}`.
- Natural sub-module: `nbcac_rr_arbiter`. It is combinational, with inputs `req[NUM_CH]` and `ptr[CH_W]`, and outputs `grant_idx` and `grant_valid`.
- One instance of the existing `nbcac_13di_encoder_core` (ports `v`, `d`).
- All registers are in the top module.

## Test plan
- **Reset/idle:** hold `rst=1` for 3 cycles with all `req_valid=1`. Required: `req_ready=0`, `out_valid=0`, `out_code=0`. After release, the first grant goes to channel 0.
- **Round-robin:** all 4 channels valid with `last=1`, data 13'h0001..13'h0004, `out_ready=1`. Required:
  - `out_ch` sequence 0,1,2,3,0;
  - each `out_code` equals a reference model of `core(data)`.
- **Packet lock:** channel 2 sends 3 words (last on the 3rd) while channel 0 is also valid. Required: `out_ch`=2,2,2, then 3 if valid, else 0. Channel 0 gets no `req_ready` during the packet.
- **Backpressure:** `out_ready=0` for 5 cycles with `out_valid=1`. Required:
  - `out_code`, `out_ch` and `out_last` stable;
  - all `req_ready=0`;
  - on release, the next word follows on the following cycle with no bubble.
- **Idle hold:** after the final word (e.g. code X) drains and no requests remain. Required: `out_valid=0` and `out_code` stays X for 10 cycles, giving zero toggles on the bus.
- **Wrap and mid-packet reset:** with `rr_ptr` at 3 and only channel 1 valid, the grant goes to 1. Then assert `rst` during a locked packet: state returns to IDLE and `rr_ptr` to 0.

Source files
------------

// File: rtl/nbcac_pkg.sv
// Shared constants and types for the NBCAC encoder arbiter slice.
package nbcac_pkg;

    localparam int NBCAC_DW = 13;
    localparam int NBCAC_CW = 18;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/nbcac_13di_encoder_core.sv
// 13-bit to 18-bit group-shielded NBCAC encoder core (combinational).
// Data wires are laid out in groups of 3,2,2,2,2,2 bits, LSB first.
// A grounded shield wire sits between adjacent groups, at wires 3, 6, 9, 12 and 15.
// A data wire never switches next to a data wire of another group.
module nbcac_13di_encoder_core
    import nbcac_pkg::*;
(
    input  logic [NBCAC_DW-1:0] v,
    output logic [NBCAC_CW-1:0] d
);

    assign d = {v[12:11], 1'b0,
                v[10:9],  1'b0,
                v[8:7],   1'b0,
                v[6:5],   1'b0,
                v[4:3],   1'b0,
                v[2:0]};

endmodule

// File: rtl/nbcac_rr_arbiter.sv
// Combinational round-robin arbiter.
// It picks the first set request at or above ptr, wrapping from NUM_CH-1 to 0.
module nbcac_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);

    localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

    // Scan the requests starting at ptr; the first hit wins.
    always_comb begin
        logic [CH_W:0] idx;
        idx         = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, ptr} + (CH_W+1)'(i);
            if (idx >= NUM_CH_V) begin
                idx = idx - NUM_CH_V;
            end
            if (!grant_valid && req[idx[CH_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/nbcac_encoder_arbiter.sv
// Shares one NBCAC encoder core between NUM_CH requesters.
// Arbitration is round-robin, and a packet locks the grant until its last word.
// The single output register holds the last codeword while idle, so the bus does not toggle.
module nbcac_encoder_arbiter
    import nbcac_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*NBCAC_DW-1:0] req_data,
    input  logic [NUM_CH-1:0]          req_last,
    output logic [NUM_CH-1:0]          req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NBCAC_CW-1:0]        out_code,
    output logic [CH_W-1:0]            out_ch,
    output logic                       out_last
);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     lock_ch;
    logic [CH_W-1:0]     arb_idx;
    logic                arb_valid;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_valid;
    logic                load;
    logic                accept;
    logic [NBCAC_DW-1:0] sel_data;
    logic                sel_last;
    logic [NBCAC_CW-1:0] enc_code;
    logic [CH_W-1:0]     ptr_inc;

    nbcac_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    nbcac_13di_encoder_core u_core (
        .v (sel_data),
        .d (enc_code)
    );

    // The output register can take a word when it is empty or draining this cycle.
    assign load = !out_valid || out_ready;

    // Nothing is handed out while reset is held, so requesters never see a ready they would lose.
    assign accept = load && grant_valid && !rst;

    assign ptr_inc = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);

    // Grant source: the round-robin search when idle, pinned to the locked channel otherwise.
    always_comb begin
        grant_idx   = arb_idx;
        grant_valid = arb_valid;
        if (state_q == ARB_LOCKED) begin
            grant_idx   = lock_ch;
            grant_valid = req_valid[lock_ch];
        end
    end

    // Steer the granted channel's word, its last flag and the one-hot ready strobe.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                sel_data     = req_data[i*NBCAC_DW +: NBCAC_DW];
                sel_last     = req_last[i];
                req_ready[i] = accept;
            end
        end
    end

    // Next arbiter state: an accepted word without last keeps or takes the lock.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = sel_last ? ARB_IDLE : ARB_LOCKED;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register, round-robin pointer and lock owner; data is held (not cleared) when idle.
    always_ff @(posedge clock) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            rr_ptr    <= '0;
            lock_ch   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_code  <= enc_code;
            out_ch    <= grant_idx;
            out_last  <= sel_last;
            if (sel_last) begin
                rr_ptr <= ptr_inc;
            end else begin
                lock_ch <= grant_idx;
            end
        end else if (out_ready && out_valid) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nbcac_encoder_arbiter.sv
// Testbench for nbcac_encoder_arbiter with NUM_CH = 4.
// It runs table-driven vectors, hand-written corner sequences and a randomized
// phase, all checked against a behavioural reference model.
module tb_nbcac_encoder_arbiter;

    localparam int N = 4;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*13-1:0] req_data = '0;
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [17:0]   out_code;
    logic [1:0]    out_ch;
    logic          out_last;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit          m_locked = 0;
    int          m_lock_ch = 0;
    int          m_ptr = 0;
    logic        m_ov = 1'b0;
    logic [17:0] m_code = '0;
    logic [1:0]  m_ch = '0;
    logic        m_last = 1'b0;
    logic [3:0]  m_rdy = '0;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] lst;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_ch;
    } vec_t;

    vec_t tbl[$];

    nbcac_encoder_arbiter #(.NUM_CH(N)) dut (
        .clock     (clock),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_ch    (out_ch),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    // Codeword: walk the 18 wires. Wires 3, 6, 9, 12 and 15 are grounded shields.
    // Every other wire takes the next data bit, LSB first.
    function automatic logic [17:0] ref_code(input logic [12:0] d);
        logic [17:0] c;
        int b;
        c = '0;
        b = 0;
        for (int w = 0; w < 18; w++) begin
            if (w >= 3 && (w % 3) == 0) begin
                c[w] = 1'b0;
            end else begin
                c[w] = d[b];
                b++;
            end
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_ready();
        int g;
        bit gv;
        g  = 0;
        gv = 0;
        if (rst) return 4'b0;
        if (m_locked) begin
            g  = m_lock_ch;
            gv = req_valid[g];
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!gv && req_valid[c]) begin
                    gv = 1;
                    g  = c;
                end
            end
        end
        if (gv && (!m_ov || out_ready)) return 4'(1 << g);
        return 4'b0;
    endfunction

    task automatic model_update(input logic [3:0] rdy);
        int g;
        g = 0;
        if (rst) begin
            m_locked = 0; m_lock_ch = 0; m_ptr = 0;
            m_ov = 1'b0; m_code = '0; m_ch = '0; m_last = 1'b0;
        end else if (rdy != 4'b0) begin
            for (int k = 0; k < N; k++) if (rdy[k]) g = k;
            m_code = ref_code(req_data[g*13 +: 13]);
            m_ch   = 2'(g);
            m_last = req_last[g];
            m_ov   = 1'b1;
            if (req_last[g]) begin
                m_locked = 0;
                m_ptr    = (g + 1) % N;
            end else begin
                m_locked  = 1;
                m_lock_ch = g;
            end
        end else if (out_ready && m_ov) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic pre(input string tag);
        #2;
        m_rdy = model_ready();
        chk({tag, " req_ready"}, 32'(req_ready), 32'(m_rdy));
    endtask

    task automatic post(input string tag);
        @(posedge clock);
        model_update(m_rdy);
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, " out_code"},  32'(out_code),  32'(m_code));
        chk({tag, " out_ch"},    32'(out_ch),    32'(m_ch));
        chk({tag, " out_last"},  32'(out_last),  32'(m_last));
    endtask

    task automatic tick(input string tag);
        pre(tag);
        post(tag);
    endtask

    initial begin
        logic [17:0] hold_x;
        logic [17:0] prev;
        int toggles;

        for (int i = 0; i < N; i++) req_data[i*13 +: 13] = 13'(i + 1);

        // reset held for 3 cycles with every channel requesting
        rst = 1'b1; req_valid = 4'hF; req_last = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pre("reset");
            chk("reset req_ready const", 32'(req_ready), 32'h0);
            post("reset");
            chk("reset out_valid const", 32'(out_valid), 32'h0);
            chk("reset out_code const", 32'(out_code), 32'h0);
        end
        rst = 1'b0;

        // round-robin, packet lock, lock owner dropping valid, backpressure, drain
        tbl.push_back('{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0});
        tbl.push_back('{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1});
        tbl.push_back('{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2});
        tbl.push_back('{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3});
        tbl.push_back('{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0});
        tbl.push_back('{4'h5, 4'h0, 1'b1, 4'h4, 1'b1, 2'd2});
        tbl.push_back('{4'h5, 4'h0, 1'b1, 4'h4, 1'b1, 2'd2});
        tbl.push_back('{4'h5, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2});
        tbl.push_back('{4'h9, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3});
        tbl.push_back('{4'h3, 4'h0, 1'b1, 4'h1, 1'b1, 2'd0});
        tbl.push_back('{4'h2, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0});
        tbl.push_back('{4'h3, 4'h1, 1'b1, 4'h1, 1'b1, 2'd0});
        for (int i = 0; i < 5; i++) tbl.push_back('{4'h2, 4'h2, 1'b0, 4'h0, 1'b1, 2'd0});
        tbl.push_back('{4'h2, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1});
        tbl.push_back('{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1});

        for (int r = 0; r < tbl.size(); r++) begin
            req_valid = tbl[r].vld;
            req_last  = tbl[r].lst;
            out_ready = tbl[r].ordy;
            pre("table");
            chk($sformatf("table[%0d] req_ready", r), 32'(req_ready), 32'(tbl[r].e_rdy));
            post("table");
            chk($sformatf("table[%0d] out_valid", r), 32'(out_valid), 32'(tbl[r].e_ov));
            chk($sformatf("table[%0d] out_ch", r), 32'(out_ch), 32'(tbl[r].e_ch));
        end

        // idle hold: the last codeword (from channel 1) stays on the bus for 10 cycles
        hold_x  = ref_code(13'd2);
        prev    = out_code;
        toggles = 0;
        for (int i = 0; i < 10; i++) begin
            tick("idle");
            chk("idle out_code held", 32'(out_code), 32'(hold_x));
            if (out_code !== prev) toggles++;
            prev = out_code;
        end
        chk("idle bus toggles", 32'(toggles), 32'h0);

        // wrap: move rr_ptr to 3, then only channel 1 requests
        req_valid = 4'h4; req_last = 4'h4;
        pre("wrap setup");
        chk("wrap setup req_ready", 32'(req_ready), 32'h4);
        post("wrap setup");
        req_valid = 4'h2; req_last = 4'h0;
        pre("wrap");
        chk("wrap req_ready", 32'(req_ready), 32'h2);
        post("wrap");
        chk("wrap out_ch", 32'(out_ch), 32'h1);
        // locked on channel 1; channel 0 alone must not be granted
        req_valid = 4'h1; req_last = 4'h1;
        pre("lock hold");
        chk("lock hold req_ready", 32'(req_ready), 32'h0);
        post("lock hold");
        // reset mid-packet drops the lock and restarts the search at channel 0
        rst = 1'b1; req_valid = 4'hF; req_last = 4'hF;
        tick("midpkt reset");
        rst = 1'b0;
        pre("after reset");
        chk("after reset req_ready", 32'(req_ready), 32'h1);
        post("after reset");
        chk("after reset out_ch", 32'(out_ch), 32'h0);

        // randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            req_valid = 4'($urandom);
            req_last  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) req_data[i*13 +: 13] = 13'($urandom);
            tick("random");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
